// File: rtl/pe_ssd_pkg.sv
// Shared constants and helpers for the SSD accumulation PE and its consumers.
package pe_ssd_pkg;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return r;
    endfunction

    localparam int unsigned LANES_DEF    = 4;
    localparam int unsigned IN_W_DEF     = 16;
    localparam int unsigned COLS_MAX_DEF = 8;
    localparam int unsigned IDX_W_DEF    = 8;

    // Derived widths for the default configuration
    localparam int unsigned L_DEF     = clog2(LANES_DEF);
    localparam int unsigned CNT_W_DEF = clog2(COLS_MAX_DEF + 1);
    localparam int unsigned OUT_W_DEF = IN_W_DEF + L_DEF + clog2(COLS_MAX_DEF);

endpackage

// File: rtl/pe_add_tree.sv
// Pipelined binary adder tree; valid and last travel alongside the partial sums.
module pe_add_tree
    import pe_ssd_pkg::*;
#(
    parameter  int unsigned LANES = LANES_DEF,
    parameter  int unsigned IN_W  = IN_W_DEF,
    localparam int unsigned LVL   = clog2(LANES),
    localparam int unsigned SUM_W = IN_W + LVL
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  in_valid,
    input  logic [LANES*IN_W-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    output logic                  out_last,
    output logic [SUM_W-1:0]      out_sum
);

    localparam int unsigned NODES = LANES - 1;

    // Heap-ordered nodes: node i adds children 2i+1 and 2i+2; indices >= NODES are lanes
    logic [SUM_W-1:0] node_q [NODES];
    logic [SUM_W-1:0] node_d [NODES];
    logic [SUM_W-1:0] all_c  [2*LANES-1];
    logic [LVL:1]     vld_q, vld_d, last_q, last_d, en;

    always_comb begin
        for (int unsigned i = 0; i < NODES; i++) all_c[i] = node_q[i];
        for (int unsigned k = 0; k < LANES; k++) begin
            all_c[NODES + k] = SUM_W'(in_data[k*IN_W +: IN_W]);
        end
    end

    // Stage k loads when its input valid is high; node depth d belongs to stage LVL-d
    always_comb begin
        en     = '0;
        last_d = '0;
        node_d = node_q;
        en[1]     = in_valid;
        last_d[1] = in_valid & in_last;
        for (int unsigned k = 2; k <= LVL; k++) begin
            en[k]     = vld_q[k-1];
            last_d[k] = vld_q[k-1] & last_q[k-1];
        end
        vld_d = en;
        if (clear) begin
            vld_d  = '0;
            last_d = '0;
        end
        for (int unsigned i = 0; i < NODES; i++) begin
            if (en[LVL + 1 - clog2(i + 2)]) node_d[i] = all_c[2*i+1] + all_c[2*i+2];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            last_q <= '0;
            for (int unsigned i = 0; i < NODES; i++) node_q[i] <= '0;
        end else begin
            vld_q  <= vld_d;
            last_q <= last_d;
            for (int unsigned i = 0; i < NODES; i++) node_q[i] <= node_d[i];
        end
    end

    assign out_valid = vld_q[LVL];
    assign out_last  = last_q[LVL];
    assign out_sum   = node_q[0];

endmodule

// File: rtl/pe_ssd_tree_acc.sv
// SSD accumulation PE: column adder tree, windowed accumulation and per-row minimum search.
module pe_ssd_tree_acc
    import pe_ssd_pkg::*;
#(
    parameter  int unsigned LANES    = LANES_DEF,
    parameter  int unsigned IN_W     = IN_W_DEF,
    parameter  int unsigned COLS_MAX = COLS_MAX_DEF,
    parameter  int unsigned IDX_W    = IDX_W_DEF,
    localparam int unsigned L        = clog2(LANES),
    localparam int unsigned CNT_W    = clog2(COLS_MAX + 1),
    localparam int unsigned OUT_W    = IN_W + L + clog2(COLS_MAX),
    localparam int unsigned SUM_W    = IN_W + L
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic [CNT_W-1:0]      cfg_cols,
    input  logic                  in_valid,
    input  logic [LANES*IN_W-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    output logic [OUT_W-1:0]      out_sum,
    output logic [IDX_W-1:0]      out_idx,
    output logic                  out_partial,
    output logic                  min_valid,
    output logic [OUT_W-1:0]      min_sum,
    output logic [IDX_W-1:0]      min_idx
);

    logic             t_valid, t_last;
    logic [SUM_W-1:0] t_sum;

    pe_add_tree #(.LANES(LANES), .IN_W(IN_W)) u_tree (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (t_valid),
        .out_last  (t_last),
        .out_sum   (t_sum)
    );

    logic [CNT_W-1:0] eff_cols_q, eff_cols_d, col_cnt_q, col_cnt_d;
    logic [OUT_W-1:0] acc_q, acc_d, run_min_q, run_min_d;
    logic [IDX_W-1:0] win_idx_q, win_idx_d, run_idx_q, run_idx_d;
    logic             have_min_q, have_min_d;
    logic             out_valid_q, out_valid_d, out_partial_q, out_partial_d;
    logic [OUT_W-1:0] out_sum_q, out_sum_d, min_sum_q, min_sum_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d, min_idx_q, min_idx_d;
    logic             min_valid_q, min_valid_d;

    logic [CNT_W-1:0] cfg_sat_c, cur_eff_c;
    logic [OUT_W-1:0] acc_sum_c, cand_sum_c;
    logic [IDX_W-1:0] cand_idx_c;
    logic             win_full_c, take_min_c;

    // Window geometry, running sum and minimum candidate for the current tree output
    always_comb begin
        if (cfg_cols == '0)                      cfg_sat_c = CNT_W'(1);
        else if (cfg_cols > CNT_W'(COLS_MAX))    cfg_sat_c = CNT_W'(COLS_MAX);
        else                                     cfg_sat_c = cfg_cols;
        cur_eff_c  = (col_cnt_q == '0) ? cfg_sat_c : eff_cols_q;
        win_full_c = (col_cnt_q == cur_eff_c - CNT_W'(1));
        acc_sum_c  = ((col_cnt_q == '0) ? OUT_W'(0) : acc_q) + OUT_W'(t_sum);
        take_min_c = !have_min_q || (acc_sum_c < run_min_q);
        cand_sum_c = take_min_c ? acc_sum_c : run_min_q;
        cand_idx_c = take_min_c ? win_idx_q : run_idx_q;
    end

    always_comb begin
        eff_cols_d    = eff_cols_q;
        col_cnt_d     = col_cnt_q;
        acc_d         = acc_q;
        win_idx_d     = win_idx_q;
        have_min_d    = have_min_q;
        run_min_d     = run_min_q;
        run_idx_d     = run_idx_q;
        out_valid_d   = 1'b0;
        out_sum_d     = out_sum_q;
        out_idx_d     = out_idx_q;
        out_partial_d = out_partial_q;
        min_valid_d   = 1'b0;
        min_sum_d     = min_sum_q;
        min_idx_d     = min_idx_q;
        if (t_valid) begin
            eff_cols_d = cur_eff_c;
            acc_d      = acc_sum_c;
            if (win_full_c || t_last) begin
                col_cnt_d     = '0;
                out_valid_d   = 1'b1;
                out_sum_d     = acc_sum_c;
                out_idx_d     = win_idx_q;
                out_partial_d = t_last && !win_full_c;
                if (t_last) begin
                    // Row end: publish the minimum including this window, then restart the row
                    win_idx_d   = '0;
                    have_min_d  = 1'b0;
                    min_valid_d = 1'b1;
                    min_sum_d   = cand_sum_c;
                    min_idx_d   = cand_idx_c;
                end else begin
                    win_idx_d  = (win_idx_q == '1) ? win_idx_q : win_idx_q + IDX_W'(1);
                    have_min_d = 1'b1;
                    run_min_d  = cand_sum_c;
                    run_idx_d  = cand_idx_c;
                end
            end else begin
                col_cnt_d = col_cnt_q + CNT_W'(1);
            end
        end
        if (clear) begin
            col_cnt_d     = '0;
            acc_d         = '0;
            win_idx_d     = '0;
            have_min_d    = 1'b0;
            run_min_d     = '0;
            run_idx_d     = '0;
            out_valid_d   = 1'b0;
            out_sum_d     = '0;
            out_idx_d     = '0;
            out_partial_d = 1'b0;
            min_valid_d   = 1'b0;
            min_sum_d     = '0;
            min_idx_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eff_cols_q    <= '0;
            col_cnt_q     <= '0;
            acc_q         <= '0;
            win_idx_q     <= '0;
            have_min_q    <= 1'b0;
            run_min_q     <= '0;
            run_idx_q     <= '0;
            out_valid_q   <= 1'b0;
            out_sum_q     <= '0;
            out_idx_q     <= '0;
            out_partial_q <= 1'b0;
            min_valid_q   <= 1'b0;
            min_sum_q     <= '0;
            min_idx_q     <= '0;
        end else begin
            eff_cols_q    <= eff_cols_d;
            col_cnt_q     <= col_cnt_d;
            acc_q         <= acc_d;
            win_idx_q     <= win_idx_d;
            have_min_q    <= have_min_d;
            run_min_q     <= run_min_d;
            run_idx_q     <= run_idx_d;
            out_valid_q   <= out_valid_d;
            out_sum_q     <= out_sum_d;
            out_idx_q     <= out_idx_d;
            out_partial_q <= out_partial_d;
            min_valid_q   <= min_valid_d;
            min_sum_q     <= min_sum_d;
            min_idx_q     <= min_idx_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_sum     = out_sum_q;
    assign out_idx     = out_idx_q;
    assign out_partial = out_partial_q;
    assign min_valid   = min_valid_q;
    assign min_sum     = min_sum_q;
    assign min_idx     = min_idx_q;

endmodule

// File: tb/tb_pe_ssd_tree_acc.sv
// Directed bench for pe_ssd_tree_acc: windows, gaps, row minimum, partial windows, clear and reset.
module tb_pe_ssd_tree_acc;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned OUT_W = 21;
    localparam int unsigned IDX_W = 8;

    logic              clk = 1'b0;
    logic              rst_n, clear, in_valid, in_last;
    logic [CNT_W-1:0]  cfg_cols;
    logic [63:0]       in_data;
    logic              out_valid, out_partial, min_valid;
    logic [OUT_W-1:0]  out_sum, min_sum;
    logic [IDX_W-1:0]  out_idx, min_idx;

    pe_ssd_tree_acc dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .cfg_cols    (cfg_cols),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_sum     (out_sum),
        .out_idx     (out_idx),
        .out_partial (out_partial),
        .min_valid   (min_valid),
        .min_sum     (min_sum),
        .min_idx     (min_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int               cyc;
        logic [OUT_W-1:0] sum;
        logic [IDX_W-1:0] idx;
        logic             part;
    } rec_t;

    rec_t oq[$];
    rec_t mq[$];

    // Log every result pulse with the cycle it was seen in
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) oq.push_back('{cyc, out_sum, out_idx, out_partial});
            if (min_valid) mq.push_back('{cyc, min_sum, min_idx, 1'b0});
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic col(input logic [63:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    function automatic logic [63:0] rep(input logic [15:0] v);
        return {v, v, v, v};
    endfunction

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (2) tick();
        oq.delete();
        mq.delete();
    endtask

    task automatic exp_out(input string tag, input int i, input int t0, input int rel,
                           input int sum, input int idx, input int part);
        if (oq.size() > i) begin
            check({tag, "_cyc"},  32'(oq[i].cyc - t0), 32'(rel));
            check({tag, "_sum"},  32'(oq[i].sum),      32'(sum));
            check({tag, "_idx"},  32'(oq[i].idx),      32'(idx));
            check({tag, "_part"}, 32'(oq[i].part),     32'(part));
        end else begin
            check({tag, "_present"}, 32'(oq.size()), 32'(i + 1));
        end
    endtask

    task automatic exp_min(input string tag, input int t0, input int rel, input int sum, input int idx);
        if (mq.size() > 0) begin
            check({tag, "_cyc"}, 32'(mq[0].cyc - t0), 32'(rel));
            check({tag, "_sum"}, 32'(mq[0].sum),      32'(sum));
            check({tag, "_idx"}, 32'(mq[0].idx),      32'(idx));
        end else begin
            check({tag, "_present"}, 32'(mq.size()), 32'(1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        rst_n    = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        cfg_cols = 4'd4;
        repeat (3) tick();
        check("rst_out_valid", 32'(out_valid),   32'd0);
        check("rst_out_sum",   32'(out_sum),     32'd0);
        check("rst_out_idx",   32'(out_idx),     32'd0);
        check("rst_partial",   32'(out_partial), 32'd0);
        check("rst_min_valid", 32'(min_valid),   32'd0);
        check("rst_min_sum",   32'(min_sum),     32'd0);
        check("rst_min_idx",   32'(min_idx),     32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Two back-to-back windows of 4 columns, all terms 1
        t0 = cyc;
        for (int c = 0; c < 8; c++) col(rep(16'd1), 1'b0);
        repeat (8) tick();
        check("t1_n", 32'(oq.size()), 32'd2);
        exp_out("t1_w0", 0, t0, 6, 16, 0, 0);
        exp_out("t1_w1", 1, t0, 10, 16, 1, 0);
        check("t1_nmin", 32'(mq.size()), 32'd0);
        do_clear();

        // Three-cycle bubble after column 2
        t0 = cyc;
        for (int c = 0; c < 3; c++) col(rep(16'd1), 1'b0);
        repeat (3) tick();
        col(rep(16'd1), 1'b0);
        repeat (8) tick();
        check("t2_n", 32'(oq.size()), 32'd1);
        exp_out("t2_w0", 0, t0, 9, 16, 0, 0);
        do_clear();

        // Row of three 2-column windows: 40, 12, 12; tie keeps index 1
        cfg_cols = 4'd2;
        t0 = cyc;
        col({16'd4, 16'd3, 16'd2, 16'd1}, 1'b0);
        col({16'd9, 16'd8, 16'd7, 16'd6}, 1'b0);
        col({16'd3, 16'd2, 16'd1, 16'd0}, 1'b0);
        col({16'd0, 16'd1, 16'd2, 16'd3}, 1'b0);
        col({16'd12, 16'd0, 16'd0, 16'd0}, 1'b0);
        col(64'd0, 1'b1);
        repeat (8) tick();
        check("t3_n", 32'(oq.size()), 32'd3);
        exp_out("t3_w0", 0, t0, 4, 40, 0, 0);
        exp_out("t3_w1", 1, t0, 6, 12, 1, 0);
        exp_out("t3_w2", 2, t0, 8, 12, 2, 0);
        check("t3_nmin", 32'(mq.size()), 32'd1);
        exp_min("t3_min", t0, 8, 12, 1);
        do_clear();

        // Window closed early by in_last, then a fresh row starts at index 0
        cfg_cols = 4'd4;
        t0 = cyc;
        col(rep(16'd1), 1'b0);
        col(rep(16'd2), 1'b0);
        col(rep(16'd3), 1'b1);
        for (int c = 0; c < 4; c++) col(rep(16'd1), 1'b0);
        repeat (8) tick();
        check("t4_n", 32'(oq.size()), 32'd2);
        exp_out("t4_w0", 0, t0, 5, 24, 0, 1);
        exp_out("t4_w1", 1, t0, 9, 16, 0, 0);
        check("t4_nmin", 32'(mq.size()), 32'd1);
        exp_min("t4_min", t0, 5, 24, 0);
        do_clear();

        // cfg_cols = 0 behaves as single-column windows
        cfg_cols = 4'd0;
        t0 = cyc;
        col(rep(16'd1), 1'b0);
        col(rep(16'd2), 1'b0);
        col(rep(16'd3), 1'b0);
        repeat (8) tick();
        check("t5_n", 32'(oq.size()), 32'd3);
        exp_out("t5_w0", 0, t0, 3, 4, 0, 0);
        exp_out("t5_w1", 1, t0, 4, 8, 1, 0);
        exp_out("t5_w2", 2, t0, 5, 12, 2, 0);
        do_clear();

        // Oversized cfg clamps to 8 columns; full-scale terms must not overflow
        cfg_cols = 4'd15;
        t0 = cyc;
        for (int c = 0; c < 8; c++) col(rep(16'hFFFF), 1'b0);
        repeat (8) tick();
        check("t6_n", 32'(oq.size()), 32'd1);
        exp_out("t6_w0", 0, t0, 10, 32'h1FFFE0, 0, 0);
        oq.delete();

        // clear mid-window, together with a valid column, discards everything
        cfg_cols = 4'd4;
        col(rep(16'd7), 1'b0);
        col(rep(16'd7), 1'b0);
        in_valid = 1'b1;
        in_data  = rep(16'd7);
        clear    = 1'b1;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        check("t7_clr_sum", 32'(out_sum), 32'd0);
        check("t7_clr_idx", 32'(out_idx), 32'd0);
        t0 = cyc;
        for (int c = 0; c < 4; c++) col(rep(16'd1), 1'b0);
        repeat (8) tick();
        check("t7_n", 32'(oq.size()), 32'd1);
        exp_out("t7_w0", 0, t0, 6, 16, 0, 0);
        oq.delete();

        // Asynchronous reset mid-window
        col(rep(16'd7), 1'b0);
        col(rep(16'd7), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t8_rst_sum", 32'(out_sum), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        t0 = cyc;
        for (int c = 0; c < 4; c++) col(rep(16'd2), 1'b0);
        repeat (8) tick();
        check("t8_n", 32'(oq.size()), 32'd1);
        exp_out("t8_w0", 0, t0, 6, 32, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
